latch_load_arbiter: RTL and testbench

- Round-robin controller that shares one load-enabled storage latch among NREQ requesters.
- Selects one requester, drives that requester's data and a one-cycle load strobe into the shared latch, then holds off for HOLD cycles before the next grant.
- Keeps a registered copy of the latched value on `out`, so requesters and downstream logic see one stable shared value.

---
 rtl/latch_load_arbiter.sv | 104 ++++++++++
 tb/tb_latch_load_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_load_arbiter.sv
// Round-robin arbiter that shares one load-enabled latch among NREQ requesters.
// Optional grant statistics counter enabled by defining LATCH_ARB_STATS_EN.
module latch_load_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int HOLD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      data_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    load,
  output logic [DW-1:0]           data_out,
  output logic [DW-1:0]           out,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
`ifdef LATCH_ARB_STATS_EN
  ,
  output logic [15:0]             grant_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [3:0]    hold_cnt;
  int            scan;

  // Scan from the highest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    scan       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan = (int'(ptr) + i) % NREQ;
      if (req[scan]) begin
        pick_idx   = scan[IW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == ST_LOAD) gnt[sel_idx] = 1'b1;
  end

  assign load = (state == ST_LOAD);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      sel_idx  <= '0;
      hold_cnt <= '0;
      data_out <= '0;
      out      <= '0;
      owner    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel_idx  <= pick_idx;
            data_out <= data_in[pick_idx*DW +: DW];
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          out      <= data_out;
          owner    <= sel_idx;
          ptr      <= (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
          hold_cnt <= 4'(HOLD);
          state    <= (HOLD > 0) ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LATCH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (state == ST_LOAD && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_latch_load_arbiter.sv
// Randomized and directed bench for latch_load_arbiter against a timestamp-based model.
// A second instance with HOLD=0 exercises back-to-back grants.
module tb_latch_load_arbiter;

  localparam int HOLD_P = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  gnt;
  logic        load;
  logic [7:0]  data_out;
  logic [7:0]  out;
  logic [1:0]  owner;
  logic        busy;

  logic [3:0]  req0 = '0;
  logic [31:0] data0 = '0;
  logic [3:0]  gnt0;
  logic        load0;
  logic [7:0]  data_out0;
  logic [7:0]  out0;
  logic [1:0]  owner0;
  logic        busy0;
`ifdef LATCH_ARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] grant_cnt0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Model: the edge number of the most recent grant decides everything else.
  int          e = 0;
  bit          have = 0;
  int          g = 0;
  int          m_idx = 0;
  int          m_ptr = 0;
  int          m_owner = 0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_out = '0;

  latch_load_arbiter #(.NREQ(4), .DW(8), .HOLD(HOLD_P)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gnt(gnt),
    .load(load), .data_out(data_out), .out(out), .owner(owner), .busy(busy)
`ifdef LATCH_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  latch_load_arbiter #(.NREQ(4), .DW(8), .HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .data_in(data0), .gnt(gnt0),
    .load(load0), .data_out(data_out0), .out(out0), .owner(owner0), .busy(busy0)
`ifdef LATCH_ARB_STATS_EN
    , .grant_cnt(grant_cnt0)
`endif
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (have && e == g) ? (4'b0001 << m_idx) : 4'b0000;
  endfunction

  function automatic logic exp_busy();
    return have && e >= g && e <= g + HOLD_P;
  endfunction

  task automatic model_reset();
    have = 0; m_ptr = 0; m_owner = 0; m_data = '0; m_out = '0;
  endtask

  task automatic tick();
    logic [3:0]  rs;
    logic [31:0] ds;
    rs = req;
    ds = data_in;
    @(posedge clk);
    #1;
    e++;
    if (have && e == g + 1) begin
      m_out   = m_data;
      m_owner = m_idx;
      m_ptr   = (m_idx + 1) % 4;
    end
    if ((!have || e >= g + HOLD_P + 2) && rs != 4'b0000) begin
      have   = 1;
      g      = e;
      m_idx  = rr_pick(rs, m_ptr);
      m_data = ds[m_idx*8 +: 8];
    end
  endtask

  task automatic apply_reset();
    req = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vectors++;
    if (gnt !== 4'b0 || load !== 1'b0 || busy !== 1'b0 || out !== 8'h00 || owner !== 2'd0 || data_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_initial: got gnt=%b load=%b busy=%b out=%h owner=%0d dout=%h expected all zero", gnt, load, busy, out, owner, data_out);
    end
    rst_n = 1'b1;
    tick();
    req = 4'b0100; data_in = 32'h77665544;
    tick();
    req = 4'b0000;
    vectors++;
    if (load !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_preload: got load=%b expected 1", load);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (gnt !== 4'b0 || load !== 1'b0 || busy !== 1'b0 || out !== 8'h00 || owner !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_midload: got gnt=%b load=%b busy=%b out=%h owner=%0d expected zeros", gnt, load, busy, out, owner);
    end
    #1 rst_n = 1'b1;
    req = 4'b1010; data_in = 32'hDDCCBBAA;
    tick();
    req = 4'b0000;
    vectors++;
    if (gnt !== 4'b0010 || gnt !== exp_gnt()) begin
      miscompares++;
      $display("[TB] FAIL reset_first_grant: got %b expected %b", gnt, 4'b0010);
    end
    repeat (4) tick();
  endtask

  task automatic test_single();
    int busy_cycles;
    apply_reset();
    tick();
    req = 4'b0100; data_in = 32'h00A50000;
    tick();
    req = 4'b0000;
    vectors++;
    if (gnt !== 4'b0100 || load !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got gnt=%b load=%b expected 0100/1", gnt, load);
    end
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cycles++;
      tick();
      vectors++;
      if (gnt !== 4'b0000 || out !== m_out || busy !== exp_busy()) begin
        miscompares++;
        $display("[TB] FAIL single_follow: got gnt=%b out=%h busy=%b expected 0000/%h/%b", gnt, out, busy, m_out, exp_busy());
      end
    end
    vectors++;
    if (busy_cycles != 3 || out !== 8'hA5 || owner !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL single_result: got busy_cycles=%0d out=%h owner=%0d expected 3/a5/2", busy_cycles, out, owner);
    end
  endtask

  task automatic test_all_requests();
    int gidx[$];
    int gedge[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req = 4'b1111; data_in = 32'h44332211;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (gnt !== exp_gnt() || out !== m_out) begin
        miscompares++;
        $display("[TB] FAIL all_req_cycle: got gnt=%b out=%h expected %b/%h", gnt, out, exp_gnt(), m_out);
      end
      if (gnt != 4'b0) begin
        for (int k = 0; k < 4; k++) if (gnt[k]) gidx.push_back(k);
        gedge.push_back(e);
      end
    end
    req = 4'b0000;
    vectors++;
    if (gidx.size() < 5) begin
      miscompares++;
      $display("[TB] FAIL all_req_count: got %0d grants expected at least 5", gidx.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (gidx[k] != exp_seq[k] || (k > 0 && gedge[k] - gedge[k-1] != 4)) begin
          miscompares++;
          $display("[TB] FAIL all_req_seq%0d: got idx=%0d gap=%0d expected idx=%0d gap=4", k, gidx[k], (k > 0) ? gedge[k] - gedge[k-1] : 4, exp_seq[k]);
        end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int seen[$];
    apply_reset();
    req = 4'b1000; data_in = 32'h9900_0000;
    tick();
    req = 4'b0000;
    repeat (3) tick();
    req = 4'b1001; data_in = 32'h3C00_00C3;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (gnt !== exp_gnt()) begin
        miscompares++;
        $display("[TB] FAIL wrap_cycle: got %b expected %b", gnt, exp_gnt());
      end
      if (gnt != 4'b0) seen.push_back(int'(gnt));
    end
    req = 4'b0000;
    vectors++;
    if (seen.size() < 2 || seen[0] != 1 || seen[1] != 8) begin
      miscompares++;
      $display("[TB] FAIL wrap_order: got %0d grants first=%0d second=%0d expected 1 then 8", seen.size(), (seen.size() > 0) ? seen[0] : -1, (seen.size() > 1) ? seen[1] : -1);
    end
    repeat (4) tick();
  endtask

  task automatic test_withdraw();
    logic [7:0] held;
    req = 4'b0001; data_in = 32'h0000_00E7;
    tick();
    req = 4'b0000;
    tick();
    held = out;
    req = 4'b0010; data_in = 32'h0000_1B00;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || out !== held || out !== 8'hE7) begin
        miscompares++;
        $display("[TB] FAIL withdraw: got gnt=%b busy=%b out=%h expected 0000/0/e7", gnt, busy, out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      data_in = $urandom;
      tick();
      vectors++;
      if (gnt !== exp_gnt() || load !== (exp_gnt() != 4'b0) || busy !== exp_busy() ||
          data_out !== m_data || out !== m_out || owner !== 2'(m_owner)) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got gnt=%b load=%b busy=%b dout=%h out=%h owner=%0d expected %b/%b/%h/%h/%0d", i, gnt, load, busy, data_out, out, owner, exp_gnt(), exp_busy(), m_data, m_out, m_owner);
      end
    end
    req = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    req0 = 4'b0001; data0 = 32'h0000_005A;
    for (int i = 0; i < 10; i++) begin
      tick();
      want = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      vectors++;
      if (gnt0 !== want || load0 !== want[0] || busy0 !== want[0] || data_out0 !== 8'h5A || owner0 !== 2'd0 ||
          (i >= 1 && out0 !== 8'h5A)) begin
        miscompares++;
        $display("[TB] FAIL hold0_%0d: got gnt=%b load=%b busy=%b dout=%h out=%h owner=%0d expected %b", i, gnt0, load0, busy0, data_out0, out0, owner0, want);
      end
`ifdef LATCH_ARB_STATS_EN
      vectors++;
      if (grant_cnt0 !== 16'((i + 1) / 2)) begin
        miscompares++;
        $display("[TB] FAIL grant_cnt_%0d: got %0d expected %0d", i, grant_cnt0, (i + 1) / 2);
      end
`endif
    end
    req0 = 4'b0000;
  endtask

  initial begin
    #12;
    test_reset();
    test_single();
    test_all_requests();
    test_wrap();
    test_withdraw();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
